// File: rtl/pipe_adder_pkg.sv
// Shared types and index helpers for the pipelined chunked adder.
package pipe_adder_pkg;

  // Per-stage control record: stage occupied flag and registered chunk carry.
  typedef struct packed {
    logic v;
    logic carry;
  } stage_ctl_t;

  // Chunk width for a W-bit adder split into N stages.
  function automatic int unsigned chunk_w(input int unsigned w, input int unsigned n);
    return w / n;
  endfunction

  // Lowest bit index of chunk k.
  function automatic int unsigned chunk_lo(input int unsigned k, input int unsigned c);
    return k * c;
  endfunction

  // Data width held by stage k: k+1 result chunks plus two operand chunks per pending chunk.
  function automatic int unsigned stage_ow(input int unsigned k, input int unsigned c,
                                           input int unsigned n);
    return c * (2 * n - k - 1);
  endfunction

  // Offset of stage k's data inside the flattened inter-stage bus.
  function automatic int unsigned stage_off(input int unsigned k, input int unsigned c,
                                            input int unsigned n);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < k; j++) begin
      off += stage_ow(j, c, n);
    end
    return off;
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline stage: adds chunk K of both operands plus incoming carry and
// shifts the remaining operand chunks forward. Data layout on input:
// {pairs N-1..K as {x_1 chunk, x_0 chunk}, result chunks K-1..0}.
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4,
  parameter int unsigned K = 0,
  localparam int unsigned C  = W / N,
  localparam int unsigned IW = C * (2 * N - K),
  localparam int unsigned OW = IW - C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_next,
  output logic          en_c,
  input  logic          v_in,
  input  logic          carry_in,
  input  logic [IW-1:0] d_in,
  output logic          v,
  output logic          carry,
  output logic [OW-1:0] d
);

  localparam int unsigned LO = chunk_lo(K, C);

  logic [C-1:0]  a0;
  logic [C-1:0]  a1;
  logic [C-1:0]  sum;
  logic          cy;
  logic [OW-1:0] nxt;
  stage_ctl_t    ctl;

  assign a0 = d_in[LO +: C];
  assign a1 = d_in[LO + C +: C];

  // Chunk add, C+1 bits wide, no sign extension.
  assign {cy, sum} = (C + 1)'(a1) + (C + 1)'(a0) + (C + 1)'(carry_in);

  // Replace the consumed operand pair with the new result chunk.
  if (K == 0 && K == N - 1) begin : g_only
    assign nxt = sum;
  end else if (K == 0) begin : g_first
    assign nxt = {d_in[IW-1:2*C], sum};
  end else if (K == N - 1) begin : g_last
    assign nxt = {sum, d_in[LO-1:0]};
  end else begin : g_mid
    assign nxt = {d_in[IW-1:LO+2*C], sum, d_in[LO-1:0]};
  end

  // Stage loads when empty or when its contents move on this cycle.
  assign en_c = !ctl.v || en_next;

  // Stage registers: load on enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl <= '0;
      d   <= '0;
    end else if (en_c) begin
      ctl.v     <= v_in;
      ctl.carry <= cy;
      d         <= nxt;
    end
  end

  assign v     = ctl.v;
  assign carry = ctl.carry;

endmodule

// File: rtl/pipe_adder_sv.sv
// Pipelined W-bit adder: N chunk stages with registered carries, valid/ready
// handshake on both sides, bubble collapsing, one add per clock.
module pipe_adder_sv
  import pipe_adder_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         c_in,
  input  logic [W-1:0] x_0,
  input  logic [W-1:0] x_1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         c_out
);

  localparam int unsigned C  = chunk_w(W, N);
  localparam int unsigned TW = stage_off(N, C, N);

  if (N == 0 || (W % N) != 0) begin : g_bad_cfg
    $error("pipe_adder_sv: W must be a nonzero multiple of N");
  end

  logic [2*W-1:0] ops;
  logic [TW-1:0]  dbus;
  logic [N-1:0]   en;
  logic [N-1:0]   v;
  logic [N-1:0]   cy;

  // Interleave operands chunk-wise so each stage peels off the lowest pair.
  for (genvar j = 0; j < N; j++) begin : g_ops
    assign ops[2*j*C +: C]     = x_0[j*C +: C];
    assign ops[2*j*C + C +: C] = x_1[j*C +: C];
  end

  // Stage chain with the enable ripple running back from out_ready.
  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int unsigned IW  = C * (2 * N - k);
    localparam int unsigned OW  = IW - C;
    localparam int unsigned OFF = stage_off(k, C, N);

    logic          en_nx;
    logic          v_i;
    logic          c_i;
    logic [IW-1:0] d_i;

    if (k == 0) begin : g_src_in
      assign v_i = in_valid;
      assign c_i = c_in;
      assign d_i = ops;
    end else begin : g_src_prev
      assign v_i = v[k-1];
      assign c_i = cy[k-1];
      assign d_i = dbus[stage_off(k - 1, C, N) +: IW];
    end

    if (k == N - 1) begin : g_en_out
      assign en_nx = out_ready;
    end else begin : g_en_next
      assign en_nx = en[k+1];
    end

    pipe_adder_stage #(
      .W(W),
      .N(N),
      .K(k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en_next  (en_nx),
      .en_c     (en[k]),
      .v_in     (v_i),
      .carry_in (c_i),
      .d_in     (d_i),
      .v        (v[k]),
      .carry    (cy[k]),
      .d        (dbus[OFF +: OW])
    );
  end

  assign in_ready  = en[0];
  assign out_valid = v[N-1];
  assign c_out     = cy[N-1];
  assign y         = dbus[stage_off(N - 1, C, N) +: W];

endmodule

// File: tb/tb_pipe_adder_sv.sv
// Directed bench for pipe_adder_sv: main 32/4 instance plus 24/3 and 8/1
// instances exercised with the back-to-back vector set.
module tb_pipe_adder_sv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        c_in;
  logic [31:0] x_0;
  logic [31:0] x_1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        c_out;

  logic        aux_en;
  logic        aux_iv;
  logic        ir24, ov24, c24;
  logic [23:0] y24;
  logic        ir8, ov8, c8;
  logic [7:0]  y8;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_out = 0;
  int unsigned cyc   = 0;

  logic [32:0] q32[$];
  logic [24:0] q24[$];
  logic [8:0]  q8[$];

  logic [31:0] ta[8];
  logic [31:0] tb[8];
  logic        tc[8];
  logic [32:0] te[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign aux_iv = in_valid & aux_en;

  pipe_adder_sv #(.W(32), .N(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .c_in(c_in),
    .x_0(x_0), .x_1(x_1), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .c_out(c_out)
  );

  pipe_adder_sv #(.W(24), .N(3)) dut24 (
    .clk(clk), .rst(rst), .in_valid(aux_iv), .in_ready(ir24), .c_in(c_in),
    .x_0(x_0[23:0]), .x_1(x_1[23:0]), .out_valid(ov24), .out_ready(out_ready),
    .y(y24), .c_out(c24)
  );

  pipe_adder_sv #(.W(8), .N(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(aux_iv), .in_ready(ir8), .c_in(c_in),
    .x_0(x_0[7:0]), .x_1(x_1[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .y(y8), .c_out(c8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] sum33(input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    return 33'(a) + 33'(b) + 33'(c);
  endfunction

  // Main output scoreboard: pop expected value on every output transfer.
  always @(negedge clk) begin
    if (rst) q32.delete();
    else if (out_valid && out_ready) begin
      n_out++;
      if (q32.size() == 0) chk("main_spurious", 64'(1), 64'(0));
      else chk("main_sum", 64'({c_out, y}), 64'(q32.pop_front()));
    end
  end

  // 24/3 instance scoreboard.
  always @(negedge clk) begin
    if (rst) q24.delete();
    else begin
      if (ov24 && out_ready) begin
        if (q24.size() == 0) chk("w24_spurious", 64'(1), 64'(0));
        else chk("w24_sum", 64'({c24, y24}), 64'(q24.pop_front()));
      end
      if (aux_iv && ir24) q24.push_back(25'(x_0[23:0]) + 25'(x_1[23:0]) + 25'(c_in));
    end
  end

  // 8/1 instance scoreboard.
  always @(negedge clk) begin
    if (rst) q8.delete();
    else begin
      if (ov8 && out_ready) begin
        if (q8.size() == 0) chk("w8_spurious", 64'(1), 64'(0));
        else chk("w8_sum", 64'({c8, y8}), 64'(q8.pop_front()));
      end
      if (aux_iv && ir8) q8.push_back(9'(x_0[7:0]) + 9'(x_1[7:0]) + 9'(c_in));
    end
  end

  // Present one op, hold until accepted, queue its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [32:0] e);
    x_0 = a; x_1 = b; c_in = c; in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("send_timeout", 64'(0), 64'(1));
    else q32.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (q32.size() == 0 && q24.size() == 0 && q8.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(q32.size() + q24.size() + q8.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic        c;
    logic [32:0] hold;
    int unsigned t0;
    logic        done;

    ta[0] = 32'h8000_0000; tb[0] = 32'h8000_0000; tc[0] = 1'b0; te[0] = 33'h1_0000_0000;
    ta[1] = 32'h1234_5678; tb[1] = 32'h0FED_CBA8; tc[1] = 1'b0; te[1] = 33'h0_2222_2220;
    ta[2] = 32'hFFFF_FFFF; tb[2] = 32'h0000_0000; tc[2] = 1'b1; te[2] = 33'h1_0000_0000;
    ta[3] = 32'h0000_0000; tb[3] = 32'h0000_0000; tc[3] = 1'b0; te[3] = 33'h0_0000_0000;
    ta[4] = 32'hFFFF_FFFF; tb[4] = 32'hFFFF_FFFF; tc[4] = 1'b1; te[4] = 33'h1_FFFF_FFFF;
    ta[5] = 32'h0000_00FF; tb[5] = 32'h0000_0001; tc[5] = 1'b0; te[5] = 33'h0_0000_0100;
    ta[6] = 32'h00FF_FFFF; tb[6] = 32'h0000_0000; tc[6] = 1'b1; te[6] = 33'h0_0100_0000;
    ta[7] = 32'h7FFF_FFFF; tb[7] = 32'h0000_0001; tc[7] = 1'b0; te[7] = 33'h0_8000_0000;

    rst = 1'b1; in_valid = 1'b0; c_in = 1'b0; x_0 = '0; x_1 = '0;
    out_ready = 1'b1; aux_en = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_c_out", 64'(c_out), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Full-width carry ripple and latency.
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 33'h1_0000_0000);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("latency_ov", 64'(out_valid), 64'(i == 4));
    end
    chk("wrap_y", 64'(y), 64'(0));
    chk("wrap_c_out", 64'(c_out), 64'(1));
    wait_drain();

    // Back-to-back ops on all three parametrisations.
    aux_en = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) send(ta[i], tb[i], tc[i], te[i]);
      else begin
        a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
        send(a, b, c, sum33(a, b, c));
      end
    end
    chk("b2b_cycles", 64'(cyc - t0), 64'(16));
    wait_drain();
    aux_en = 1'b0;

    // Fill under stall, hold stable, then drain while accepting.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      send(a, b, c, sum33(a, b, c));
    end
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_out_valid", 64'(out_valid), 64'(1));
    hold = {c_out, y};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out", 64'({out_valid, c_out, y}), 64'({1'b1, hold}));
      chk("stall_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    t0 = n_out;
    for (int i = 0; i < 2; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      send(a, b, c, sum33(a, b, c));
    end
    wait_drain();
    chk("drain_count", 64'(n_out - t0), 64'(6));

    // Stalled output with empty stages behind still accepts.
    out_ready = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 33'h0_0000_0003);
    repeat (4) @(negedge clk);
    chk("bubble_out_valid", 64'(out_valid), 64'(1));
    chk("bubble_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000);
    out_ready = 1'b1;
    wait_drain();

    // Sparse input with random output stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
          send(a, b, c, sum33(a, b, c));
          if (i % 2 == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset with ops in flight drops them.
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      send(a, b, c, sum33(a, b, c));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    end
    chk("final_queues", 64'(q32.size() + q24.size() + q8.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
